// File: rtl/ordering_pkg.sv
// ordering_pkg
// Shared constants and types for the ordering-buffer front end.
//   ID_W / NUM_IDS : ID width and size of the ID pool
//   PAYLOAD_W      : payload width, must match the ordering buffer
//   stage_state_t  : state of the one-deep output register
//   rx_req_t       : contents of the staged request (id, payload, order)
//   first_zero_idx : lowest-index clear bit of an ID bitmap
package ordering_pkg;

  localparam int ID_W      = 3;
  localparam int NUM_IDS   = 2 ** ID_W;
  localparam int PAYLOAD_W = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_state_t;

  typedef struct packed {
    logic [ID_W-1:0]      id;
    logic [PAYLOAD_W-1:0] payload;
    logic                 order;
  } rx_req_t;

  // Scanning from the top down lets the lowest clear bit win. The caller
  // must separately check that at least one bit is clear.
  function automatic logic [ID_W-1:0] first_zero_idx(input logic [NUM_IDS-1:0] bits);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      if (!bits[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ordering_rr_arb.sv
// ordering_rr_arb
// Round-robin arbiter with its priority pointer held internally.
//   clk, reset : clock, synchronous active-high reset
//   req        : per-requester request vector
//   en         : grant permitted this cycle (downstream can accept)
//   grant      : one-hot grant, zero when en is low or nobody requests
//   grant_idx  : index of the winning requester (meaningful with a grant)
module ordering_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Walk requesters starting at the pointer; the first active one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (en && found) grant[grant_idx] = 1'b1;
  end

  // Priority moves to the requester just after the winner, only on a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (en && found) begin
      if (grant_idx == IDX_W'(NUM_REQ - 1)) ptr <= '0;
      else                                  ptr <= grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/ordering_req_arb.sv
// ordering_req_arb
// Front-end scheduler for the 8-entry ordering buffer. Arbitrates requesters
// round-robin onto the buffer RX port, tags each accepted request with a free
// ID from an 8-entry pool, and frees the ID when the buffer's TX handshake for
// it is seen.
//   clk, reset     : clock, synchronous active-high reset
//   req_valid_i    : per-requester valid
//   req_payload_i  : packed payloads, requester k at [k*PAYLOAD_W +: PAYLOAD_W]
//   req_order_i    : per-requester ordered flag
//   req_ready_o    : one-hot grant
//   req_id_o       : ID allocated to the granted request
//   rx_*_o / rx_ready_i : registered request toward the ordering buffer
//   tx_valid_i, tx_ready_i, tx_id_i : monitored buffer TX handshake
//   ids_busy_o     : bitmap of allocated IDs
//   err_o          : sticky flag, a non-allocated ID was released
module ordering_req_arb #(
  parameter int NUM_REQ   = 4,
  parameter int PAYLOAD_W = 16,
  parameter int ID_W      = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_payload_i,
  input  logic [NUM_REQ-1:0]             req_order_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic [ID_W-1:0]                req_id_o,
  output logic                           rx_valid_o,
  output logic [ID_W-1:0]                rx_id_o,
  output logic [PAYLOAD_W-1:0]           rx_payload_o,
  output logic                           rx_order_o,
  input  logic                           rx_ready_i,
  input  logic                           tx_valid_i,
  input  logic                           tx_ready_i,
  input  logic [ID_W-1:0]                tx_id_i,
  output logic [(2**ID_W)-1:0]           ids_busy_o,
  output logic                           err_o
);

  import ordering_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  stage_state_t         state;
  stage_state_t         state_next;
  rx_req_t              stage_q;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_fire;
  logic                 arb_en;
  logic                 pool_full;
  logic                 drain;
  logic [ID_W-1:0]      alloc_id;
  logic [PAYLOAD_W-1:0] sel_payload;
  logic                 sel_order;
  logic                 release_fire;
  logic                 release_ok;
  logic [(2**ID_W)-1:0] ids_busy_q;
  logic [(2**ID_W)-1:0] ids_busy_next;
  logic                 err_q;

  // Allocation looks only at the registered bitmap, so an ID released this
  // cycle cannot be handed out until the next one.
  assign pool_full = &ids_busy_q;
  assign alloc_id  = first_zero_idx(ids_busy_q);
  assign drain     = (state == FULL) && rx_ready_i;

  // A grant needs room in the stage (empty, or emptying this cycle) and a
  // free ID; reset blocks grants so nothing is accepted and then discarded.
  assign arb_en = ((state == EMPTY) || rx_ready_i) && !pool_full && !reset;

  ordering_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid_i),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign grant_fire  = |grant;
  assign req_ready_o = grant;
  assign req_id_o    = alloc_id;

  always_comb begin
    sel_payload = '0;
    sel_order   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_payload = req_payload_i[k*PAYLOAD_W +: PAYLOAD_W];
        sel_order   = req_order_i[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  // A grant always (re)fills the stage; without one, a drain empties it.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (grant_fire) state_next = FULL;
      FULL:    if (!grant_fire && drain) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Staged data only changes on a grant, which cannot happen while the
  // buffer is stalling a full stage, so rx_* hold under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else if (grant_fire) begin
      stage_q.id      <= alloc_id;
      stage_q.payload <= sel_payload;
      stage_q.order   <= sel_order;
    end
  end

  // A release of a clear bit leaves the bitmap untouched and is flagged.
  // Allocated and released IDs can never coincide (one is clear, the other
  // set), so both updates apply independently.
  assign release_fire = tx_valid_i && tx_ready_i;
  assign release_ok   = release_fire && ids_busy_q[tx_id_i];

  always_comb begin
    ids_busy_next = ids_busy_q;
    if (release_ok) ids_busy_next[tx_id_i]  = 1'b0;
    if (grant_fire) ids_busy_next[alloc_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ids_busy_q <= '0;
      err_q      <= 1'b0;
    end else begin
      ids_busy_q <= ids_busy_next;
      if (release_fire && !release_ok) err_q <= 1'b1;
    end
  end

  assign rx_valid_o   = (state == FULL);
  assign rx_id_o      = stage_q.id;
  assign rx_payload_o = stage_q.payload;
  assign rx_order_o   = stage_q.order;
  assign ids_busy_o   = ids_busy_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_ordering_req_arb.sv
// tb_ordering_req_arb
// Directed bench for ordering_req_arb. Expected RX transfers are queued as
// requests are granted and a negedge monitor pops and compares them whenever
// the DUT completes an RX handshake.
module tb_ordering_req_arb;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid_i;
  logic [63:0] req_payload_i;
  logic [3:0]  req_order_i;
  logic [3:0]  req_ready_o;
  logic [2:0]  req_id_o;
  logic        rx_valid_o;
  logic [2:0]  rx_id_o;
  logic [15:0] rx_payload_o;
  logic        rx_order_o;
  logic        rx_ready_i;
  logic        tx_valid_i;
  logic        tx_ready_i;
  logic [2:0]  tx_id_i;
  logic [7:0]  ids_busy_o;
  logic        err_o;

  typedef struct {
    logic [2:0]  id;
    logic [15:0] payload;
    logic        order;
  } exp_t;

  exp_t        expq[$];
  logic [15:0] pay[4];
  int          checks;
  int          failures;

  ordering_req_arb #(
    .NUM_REQ   (4),
    .PAYLOAD_W (16),
    .ID_W      (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_i   (req_valid_i),
    .req_payload_i (req_payload_i),
    .req_order_i   (req_order_i),
    .req_ready_o   (req_ready_o),
    .req_id_o      (req_id_o),
    .rx_valid_o    (rx_valid_o),
    .rx_id_o       (rx_id_o),
    .rx_payload_o  (rx_payload_o),
    .rx_order_o    (rx_order_o),
    .rx_ready_i    (rx_ready_i),
    .tx_valid_i    (tx_valid_i),
    .tx_ready_i    (tx_ready_i),
    .tx_id_i       (tx_id_i),
    .ids_busy_o    (ids_busy_o),
    .err_o         (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid);
    req_valid_i   = valid;
    req_payload_i = {pay[3], pay[2], pay[1], pay[0]};
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [2:0] id, input int k);
    exp_t e;
    e.id      = id;
    e.payload = pay[k];
    e.order   = req_order_i[k];
    expq.push_back(e);
  endtask

  // Monitor: every completed RX handshake must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && rx_valid_o && rx_ready_i) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL rx_unexpected: got id %0d payload 0x%0h, expected no transfer", rx_id_o, rx_payload_o);
      end else begin
        e = expq.pop_front();
        checkOutput("rx_id", 32'(rx_id_o), 32'(e.id));
        checkOutput("rx_payload", 32'(rx_payload_o), 32'(e.payload));
        checkOutput("rx_order", 32'(rx_order_o), 32'(e.order));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset       = 1'b1;
    rx_ready_i  = 1'b1;
    tx_valid_i  = 1'b0;
    tx_ready_i  = 1'b0;
    tx_id_i     = '0;
    req_order_i = '0;
    for (int k = 0; k < 4; k++) pay[k] = '0;
    applyStimulus(4'b0000);

    // Reset state; no grants while reset is held even with requests present
    nextCycle();
    applyStimulus(4'b1111);
    @(negedge clk);
    checkOutput("ready_in_reset", 32'(req_ready_o), 32'h0);
    nextCycle();
    reset = 1'b0;
    applyStimulus(4'b0000);
    @(negedge clk);
    checkOutput("rst_rx_valid", 32'(rx_valid_o), 32'h0);
    checkOutput("rst_rx_id", 32'(rx_id_o), 32'h0);
    checkOutput("rst_rx_payload", 32'(rx_payload_o), 32'h0);
    checkOutput("rst_rx_order", 32'(rx_order_o), 32'h0);
    checkOutput("rst_busy", 32'(ids_busy_o), 32'h00);
    checkOutput("rst_err", 32'(err_o), 32'h0);

    // Single request
    nextCycle();
    pay[0]      = 16'hA5A5;
    req_order_i = 4'b0001;
    applyStimulus(4'b0001);
    @(negedge clk);
    checkOutput("single_ready", 32'(req_ready_o), 32'h1);
    checkOutput("single_id", 32'(req_id_o), 32'h0);
    pushExp(3'd0, 0);
    nextCycle();
    applyStimulus(4'b0000);
    @(negedge clk);
    checkOutput("single_rx_valid", 32'(rx_valid_o), 32'h1);
    checkOutput("single_rx_id", 32'(rx_id_o), 32'h0);
    checkOutput("single_rx_payload", 32'(rx_payload_o), 32'hA5A5);
    checkOutput("single_rx_order", 32'(rx_order_o), 32'h1);
    checkOutput("single_busy", 32'(ids_busy_o), 32'h01);

    // Bad release of ID 5 while only ID 0 is allocated
    nextCycle();
    tx_valid_i = 1'b1;
    tx_ready_i = 1'b1;
    tx_id_i    = 3'd5;
    nextCycle();
    tx_valid_i = 1'b0;
    tx_ready_i = 1'b0;
    @(negedge clk);
    checkOutput("bad_rel_busy", 32'(ids_busy_o), 32'h01);
    checkOutput("bad_rel_err", 32'(err_o), 32'h1);
    nextCycle();
    @(negedge clk);
    checkOutput("bad_rel_err_sticky", 32'(err_o), 32'h1);
    nextCycle();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("err_cleared", 32'(err_o), 32'h0);
    checkOutput("busy_cleared", 32'(ids_busy_o), 32'h00);

    // Round robin with all requesters active until the pool is exhausted
    for (int k = 0; k < 4; k++) pay[k] = 16'hC0D0 + 16'(k);
    req_order_i = 4'b0101;
    nextCycle();
    applyStimulus(4'b1111);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("rr_ready", 32'(req_ready_o), 32'(4'b0001 << (i % 4)));
      checkOutput("rr_id", 32'(req_id_o), 32'(i));
      pushExp(3'(i), i % 4);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("full_busy", 32'(ids_busy_o), 32'hFF);
    checkOutput("full_no_grant", 32'(req_ready_o), 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("full_stall", 32'(req_ready_o), 32'h0);

    // Release ID 3: unusable in the release cycle, granted the cycle after
    nextCycle();
    tx_valid_i = 1'b1;
    tx_ready_i = 1'b1;
    tx_id_i    = 3'd3;
    @(negedge clk);
    checkOutput("rel_same_cycle", 32'(req_ready_o), 32'h0);
    nextCycle();
    tx_valid_i = 1'b0;
    tx_ready_i = 1'b0;
    @(negedge clk);
    checkOutput("rel_busy", 32'(ids_busy_o), 32'hF7);
    checkOutput("reuse_ready", 32'(req_ready_o), 32'h1);
    checkOutput("reuse_id", 32'(req_id_o), 32'h3);
    pushExp(3'd3, 0);

    // Backpressure with a free ID available: stage holds, nothing granted
    nextCycle();
    rx_ready_i = 1'b0;
    tx_valid_i = 1'b1;
    tx_ready_i = 1'b1;
    tx_id_i    = 3'd6;
    nextCycle();
    tx_valid_i = 1'b0;
    tx_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_no_grant", 32'(req_ready_o), 32'h0);
      checkOutput("bp_rx_valid", 32'(rx_valid_o), 32'h1);
      checkOutput("bp_rx_id", 32'(rx_id_o), 32'h3);
      checkOutput("bp_rx_payload", 32'(rx_payload_o), 32'hC0D0);
      checkOutput("bp_busy", 32'(ids_busy_o), 32'hBF);
      nextCycle();
    end
    rx_ready_i = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_ready", 32'(req_ready_o), 32'h2);
    checkOutput("bp_release_id", 32'(req_id_o), 32'h6);
    pushExp(3'd6, 1);
    nextCycle();
    applyStimulus(4'b0000);
    @(negedge clk);
    checkOutput("bp_busy_after", 32'(ids_busy_o), 32'hFF);
    nextCycle();

    // Mid-operation reset with the stage full and IDs 0..5 allocated
    reset = 1'b1;
    nextCycle();
    reset  = 1'b0;
    pay[0] = 16'h0BEE;
    applyStimulus(4'b0001);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("pre_rst_ready", 32'(req_ready_o), 32'h1);
      checkOutput("pre_rst_id", 32'(req_id_o), 32'(i));
      if (i < 5) pushExp(3'(i), 0);
      nextCycle();
    end
    rx_ready_i = 1'b0;
    reset      = 1'b1;
    applyStimulus(4'b0000);
    @(negedge clk);
    checkOutput("pre_rst_busy", 32'(ids_busy_o), 32'h3F);
    checkOutput("pre_rst_full", 32'(rx_valid_o), 32'h1);
    nextCycle();
    reset      = 1'b0;
    rx_ready_i = 1'b1;
    pay[0]     = 16'h1234;
    pay[1]     = 16'h5678;
    applyStimulus(4'b1111);
    @(negedge clk);
    checkOutput("post_rst_rx_valid", 32'(rx_valid_o), 32'h0);
    checkOutput("post_rst_busy", 32'(ids_busy_o), 32'h00);
    checkOutput("post_rst_err", 32'(err_o), 32'h0);
    checkOutput("post_rst_ready", 32'(req_ready_o), 32'h1);
    checkOutput("post_rst_id", 32'(req_id_o), 32'h0);
    pushExp(3'd0, 0);
    nextCycle();
    applyStimulus(4'b0000);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("queue_drained", 32'(expq.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/ordering_req_arb.md
Name: ordering_req_arb

Overview:
Front-end scheduler for the 8-entry ordering buffer. It arbitrates NUM_REQ requesters round-robin onto the buffer's single RX port and allocates each granted request a unique 3-bit ID from an 8-ID pool. It releases an ID when the buffer's TX handshake for that ID is observed. Because no two live entries share an ID, ID-based retire stays unambiguous. Sits directly upstream of the ordering buffer RX interface and passively monitors its TX interface.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
PAYLOAD_W, 16, payload width; must match the ordering buffer
ID_W, 3, ID width; pool size NUM_IDS = 2**ID_W = 8

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid_i  in  NUM_REQ  per-requester request valid
req_payload_i  in  NUM_REQ*PAYLOAD_W  per-requester payload; requester k uses slice [k*PAYLOAD_W +: PAYLOAD_W]
req_order_i  in  NUM_REQ  per-requester ordered flag
req_ready_o  out  NUM_REQ  one-hot grant; request k is accepted when req_valid_i[k] & req_ready_o[k]
req_id_o  out  ID_W  ID allocated to the accepted request; valid only with a grant
rx_valid_o  out  1  to ordering buffer rx_valid_i
rx_id_o  out  ID_W  to ordering buffer rx_id_i
rx_payload_o  out  PAYLOAD_W  to ordering buffer rx_payload_i
rx_order_o  out  1  to ordering buffer rx_order_i
rx_ready_i  in  1  from ordering buffer rx_ready_o
tx_valid_i  in  1  monitored ordering buffer tx_valid_o
tx_ready_i  in  1  monitored downstream tx_ready_i
tx_id_i  in  ID_W  monitored ordering buffer tx_id_o
ids_busy_o  out  NUM_IDS  registered bitmap of allocated IDs
err_o  out  1  sticky: release of a non-allocated ID was observed

Behaviour:
- Output stage is a one-deep register with states EMPTY and FULL.
  - EMPTY -> FULL on a grant.
  - FULL -> EMPTY on (rx_valid_o & rx_ready_i) with no new grant.
  - FULL -> FULL on a drain and a grant in the same cycle.
  - rx_* outputs come straight from flops; rx_id_o, rx_payload_o and rx_order_o hold stable while rx_valid_o & ~rx_ready_i.
- Reset values:
  - rx_valid_o=0; rx_id_o, rx_payload_o and rx_order_o=0.
  - ids_busy_o=8'h00; err_o=0; round-robin pointer=0 (requester 0 has highest priority).
  - req_ready_o=0 while reset is asserted.
  - A reset mid-operation discards the staged request and frees all IDs; in-flight buffer entries are the system's responsibility.
- Grant condition (combinational, cycle N): |req_valid_i & (stage EMPTY | rx_ready_i) & free ID available & ~reset.
- Only one requester is granted per cycle; req_ready_o is zero for non-selected requesters.
- Arbitration:
  - Round-robin starting at pointer p: the first k in p, p+1, …, NUM_REQ-1, 0, … with req_valid_i[k] set wins.
  - After a grant to k, p <= (k+1) mod NUM_REQ.
  - p is unchanged when there is no grant.
- ID allocation:
  - The lowest-index clear bit of ids_busy_o (the registered value) is allocated.
  - That ID is driven on req_id_o in cycle N and on rx_id_o from cycle N+1.
- Latency: grant in cycle N -> rx_valid_o=1 in N+1. Sustained throughput is 1 request/cycle while rx_ready_i=1 and IDs are free.
- ID release:
  - Occurs when tx_valid_i & tx_ready_i; bit tx_id_i of ids_busy_o is cleared at the next edge.
  - A freed ID is not allocatable in the same cycle; it is first usable in the cycle after the release.
  - Allocation and release of different IDs in the same cycle both take effect.
- Pool exhaustion: when ids_busy_o==8'hFF there are no grants, and requesters stall with no loss.
- Error case: a release of an ID whose busy bit is 0 is ignored for the bitmap and sets err_o=1 until reset.
- Requester-side protocol: a requester holds its valid and payload until granted. The block does not check this.

Decomposition:
- Package ordering_pkg: ID_W, NUM_IDS, PAYLOAD_W constants; rx_req_t packed struct {id, payload, order}; function first_zero_idx() for free-ID select.
- Sub-module ordering_rr_arb: combinational round-robin arbiter (req vector, pointer -> one-hot grant, index) with the pointer flop inside. The ID pool and output stage stay in the top module.

Test Plan:
- Single request: reset, then req_valid_i=4'b0001, payload 16'hA5A5, order=1 -> req_ready_o=4'b0001 and req_id_o=0 in cycle N; rx_valid_o=1, rx_id_o=0, rx_payload_o=16'hA5A5, rx_order_o=1 in N+1; ids_busy_o=8'h01.
- Round-robin fairness: all four requesters valid continuously, rx_ready_i=1 -> grants in order 0,1,2,3,0,… with IDs 0..7 in order; after 8 grants ids_busy_o=8'hFF and req_ready_o=0.
- Backpressure: rx_ready_i=0 with stage FULL for 5 cycles -> rx_* stable, no grants. rx_ready_i=1 -> the staged item drains and a new grant occurs in the same cycle.
- Release and reuse: pool full, TX handshake with tx_id_i=3 in cycle M -> ids_busy_o=8'hF7 at M+1; the next grant in M+1 gets ID 3; no grant uses ID 3 in cycle M.
- Bad release: with ids_busy_o=8'h01, a TX handshake with tx_id_i=5 -> ids_busy_o unchanged and err_o=1 until reset.
- Mid-operation reset: stage FULL, ids_busy_o=8'h3F, reset asserted for 1 cycle -> next cycle rx_valid_o=0, ids_busy_o=0, err_o=0, and the first grant goes to requester 0.
